signed_min_max: RTL and testbench
=================================

# signed_min_max

Streaming signed minimum/maximum tracker that sits directly downstream of the `slt` comparator and instantiates it twice: once for the min path and once for the max path. It accepts a frame of signed N-bit samples over a valid/ready handshake. It tracks the running minimum, running maximum and sample count. On the frame's last beat it presents a registered result on an output valid/ready handshake.

## Interface
- `N`, 32, sample width; samples are two's-complement signed.
- `CNT_W`, 16, sample counter width.

- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  upstream has a sample.
- `in_ready`  output  1  block accepts a sample this cycle.
- `in_data`  input  N  signed sample.
- `in_last`  input  1  sample is the final beat of its frame.
- `out_valid`  output  1  result available.
- `out_ready`  input  1  downstream consumes the result.
- `out_min`  output  N  signed minimum of the frame.
- `out_max`  output  N  signed maximum of the frame.
- `out_count`  output  CNT_W  number of samples in the frame, saturating.
- `out_sat`  output  1  `out_count` saturated during the frame.

## Operation
- There are two states: ACCUM and REPORT. Reset enters ACCUM.
- A beat is accepted when `in_valid & in_ready`. An output transfer happens when `out_valid & out_ready`.
- `in_ready` = (state == ACCUM). `out_valid` = (state == REPORT), and it is registered.
- Accepted beat with running count == 0: min ← `in_data`, max ← `in_data`, count ← 1, sat ← 0.
- Accepted beat with running count > 0:
  - min ← `in_data` if slt(`in_data`, min), else min is unchanged.
  - max ← `in_data` if slt(max, `in_data`), else max is unchanged.
  - Equal values never replace the stored value.
- Count increments by 1 and saturates at 2^CNT_W − 1. `sat` sets when an increment is attempted at the saturated value, and it stays set until the frame is reported.
- Comparisons are full signed compares. Operands with differing sign must be ordered correctly, including the extreme pair `0x7FFF_FFFF` vs `0x8000_0000`.
- Accepted beat with `in_last` = 1: the updated min, max, count and sat (including this beat) load into the `out_*` registers, and the state moves to REPORT.
- In REPORT:
  - `out_*` hold stable while `out_ready` = 0.
  - `in_ready` = 0, so upstream stalls.
- Output transfer: the state moves to ACCUM, and the running count and sat clear.
  - `out_*` keep their last values; they are don't-care while `out_valid` = 0.
- `in_valid` = 0 in ACCUM leaves all state unchanged. There is no timeout.
- Reset asserted mid-frame or mid-REPORT discards the partial frame and any unconsumed result. No output transfer is produced.

## Timing
- Reset values:
  - state = ACCUM
  - `in_ready` = 1
  - `out_valid` = 0
  - `out_min` = 0, `out_max` = 0, `out_count` = 0, `out_sat` = 0
  - running min/max/count/sat = 0
- Reset takes effect asynchronously on assertion. Deassertion is sampled at the next rising edge.
- Throughput: one sample per cycle in ACCUM.
- Latency: the last beat is accepted at edge k; `out_valid` = 1 from edge k, visible in cycle k+1.
- Output transfer at edge m: `in_ready` = 1 from edge m, so the next frame's first beat can be accepted at edge m+1.
- This gives a minimum of one bubble cycle between frames: the REPORT cycle.
- Comparator paths are combinational within one cycle. There is no additional pipeline stage.

## Test plan
- Reset check: hold `rst` = 0 mid-simulation → `in_ready` = 1, `out_valid` = 0, all `out_*` = 0 immediately, without waiting for a clock edge.
- Basic frame: samples 5, −3, 7, 0 (last on 0), `out_ready` = 1 → `out_valid` one cycle after the last beat, with `out_min` = −3, `out_max` = 7, `out_count` = 4, `out_sat` = 0.
- Sign extremes: frame `0x7FFF_FFFF`, `0x8000_0000`, −1 (last) → `out_min` = `0x8000_0000`, `out_max` = `0x7FFF_FFFF`, `out_count` = 3.
- Single-beat and ties:
  - frame {−1 with last} → min = max = −1, count = 1.
  - frame 4, 4, 4 (last) → min = max = 4, count = 3.
- Backpressure: after a frame, hold `out_ready` = 0 for 3 cycles → `out_*` stable, `in_ready` = 0. Upstream holds `in_valid` = 1 with sample 9, which must not be accepted. Then `out_ready` = 1 → 9 is accepted as the first beat of the next frame on the following cycle.
- Saturation and mid-frame reset:
  - `CNT_W` = 2, five samples → `out_count` = 3, `out_sat` = 1.
  - Separately, pulse `rst` low after 2 beats → no `out_valid`. The next frame of {10 with last} reports count = 1, min = max = 10.

Source files
------------

// File: rtl/signed_min_max.sv
// Streaming signed min/max tracker: accumulates a frame of samples on a
// valid/ready input and reports min, max and a saturating count per frame.

module slt #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         lt
);
    assign lt = $signed(a) < $signed(b);
endmodule

module signed_min_max #(
    parameter int N     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_min,
    output logic [N-1:0]     out_max,
    output logic [CNT_W-1:0] out_count,
    output logic             out_sat
);
    typedef enum logic {
        ACCUM  = 1'b0,
        REPORT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t state, state_nxt;

    logic [N-1:0]     run_min, run_max;
    logic [CNT_W-1:0] run_count;
    logic             run_sat;

    logic [N-1:0]     min_nxt, max_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic             sat_nxt;

    logic accept, xfer, first_beat, in_lt_min, max_lt_in;

    assign in_ready   = (state == ACCUM);
    assign out_valid  = (state == REPORT);
    assign accept     = in_valid & in_ready;
    assign xfer       = out_valid & out_ready;
    assign first_beat = (run_count == '0);

    slt #(.N(N)) u_slt_min (
        .a  (in_data),
        .b  (run_min),
        .lt (in_lt_min)
    );

    slt #(.N(N)) u_slt_max (
        .a  (run_max),
        .b  (in_data),
        .lt (max_lt_in)
    );

    // Running statistics including the beat currently on the input.
    // NOTE: every signal driven here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        min_nxt   = run_min;
        max_nxt   = run_max;
        count_nxt = run_count;
        sat_nxt   = run_sat;
        if (first_beat) begin
            min_nxt   = in_data;
            max_nxt   = in_data;
            count_nxt = CNT_ONE;
            sat_nxt   = 1'b0;
        end else begin
            if (in_lt_min) min_nxt = in_data;
            if (max_lt_in) max_nxt = in_data;
            if (run_count == CNT_MAX) sat_nxt   = 1'b1;
            else                      count_nxt = run_count + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == ACCUM) begin
            if (accept && in_last) state_nxt = REPORT;
        end else begin
            if (out_ready) state_nxt = ACCUM;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ACCUM;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_min   <= '0;
            run_max   <= '0;
            run_count <= '0;
            run_sat   <= 1'b0;
            out_min   <= '0;
            out_max   <= '0;
            out_count <= '0;
            out_sat   <= 1'b0;
        end else if (xfer) begin
            // Result consumed: the next accepted beat starts a fresh frame.
            run_count <= '0;
            run_sat   <= 1'b0;
        end else if (accept) begin
            run_min   <= min_nxt;
            run_max   <= max_nxt;
            run_count <= count_nxt;
            run_sat   <= sat_nxt;
            if (in_last) begin
                out_min   <= min_nxt;
                out_max   <= max_nxt;
                out_count <= count_nxt;
                out_sat   <= sat_nxt;
            end
        end
    end
endmodule

// File: tb/tb_signed_min_max.sv
// Self-checking bench for signed_min_max: directed table, hand-written
// handshake/reset sequences and random frames against a reference model.

module tb_signed_min_max;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_last, out_ready;
    logic [31:0] in_data;

    logic        in_ready, out_valid, out_sat;
    logic [31:0] out_min, out_max;
    logic [15:0] out_count;

    logic        s_in_ready, s_out_valid, s_out_sat;
    logic [31:0] s_out_min, s_out_max;
    logic [1:0]  s_out_count;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] frame_q[$];

    always #5 clk = ~clk;

    signed_min_max #(.N(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_min(out_min), .out_max(out_max),
        .out_count(out_count), .out_sat(out_sat)
    );

    signed_min_max #(.N(32), .CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_min(s_out_min), .out_max(s_out_max),
        .out_count(s_out_count), .out_sat(s_out_sat)
    );

    typedef struct packed {
        logic [2:0]       len;
        logic [5:0][31:0] s;
        logic [31:0]      emin;
        logic [31:0]      emax;
        logic [15:0]      ecnt;
        logic [1:0]       scnt;
        logic             ssat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input int len, input logic [31:0] a, b, c, d, e,
                                input logic [31:0] emin, emax, input int ecnt,
                                input int scnt, input bit ssat);
        vec_t v;
        v.len  = 3'(len);
        v.s    = {32'd0, e, d, c, b, a};
        v.emin = emin;
        v.emax = emax;
        v.ecnt = 16'(ecnt);
        v.scnt = 2'(scnt);
        v.ssat = ssat;
        return v;
    endfunction

    task automatic send_frame();
        for (int i = 0; i < frame_q.size(); i++) begin
            int budget = 0;
            in_valid = 1'b1;
            in_data  = frame_q[i];
            in_last  = (i == frame_q.size() - 1);
            while (!in_ready && budget < 20) begin
                step();
                budget++;
            end
            if (budget == 20) check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Checks the presented result, optionally stalls, then consumes it.
    task automatic check_result(input logic [31:0] emin, emax, input logic [15:0] ecnt,
                                input bit esat, input logic [1:0] scnt, input bit ssat,
                                input int stall);
        check("out_valid", {31'd0, out_valid}, 32'd1);
        check("out_min", out_min, emin);
        check("out_max", out_max, emax);
        check("out_count", {16'd0, out_count}, {16'd0, ecnt});
        check("out_sat", {31'd0, out_sat}, {31'd0, esat});
        check("small_count", {30'd0, s_out_count}, {30'd0, scnt});
        check("small_sat", {31'd0, s_out_sat}, {31'd0, ssat});
        check("small_min", s_out_min, emin);
        check("small_max", s_out_max, emax);
        out_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            step();
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_ready", {31'd0, in_ready}, 32'd0);
            check("stall_min", out_min, emin);
            check("stall_max", out_max, emax);
        end
        out_ready = 1'b1;
        step();
        check("xfer_valid", {31'd0, out_valid}, 32'd0);
        check("xfer_ready", {31'd0, in_ready}, 32'd1);
    endtask

    // Reference: plain signed min/max over the frame, count clipped to 2^w-1.
    task automatic model_check(input int stall);
        int          mn, mx, len;
        int          s_lim;
        mn    = $signed(frame_q[0]);
        mx    = $signed(frame_q[0]);
        len   = frame_q.size();
        s_lim = 3;
        foreach (frame_q[i]) begin
            if ($signed(frame_q[i]) < mn) mn = $signed(frame_q[i]);
            if ($signed(frame_q[i]) > mx) mx = $signed(frame_q[i]);
        end
        check_result(mn, mx, 16'(len), 1'b0,
                     2'((len > s_lim) ? s_lim : len), (len > s_lim), stall);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[7];
        logic [31:0] held_min, held_max;

        vecs[0] = mk(4, 32'd5, 32'hFFFF_FFFD, 32'd7, 32'd0, 32'd0,
                     32'hFFFF_FFFD, 32'd7, 4, 3, 1'b1);
        vecs[1] = mk(3, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0,
                     32'h8000_0000, 32'h7FFF_FFFF, 3, 3, 1'b0);
        vecs[2] = mk(1, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0,
                     32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 1'b0);
        vecs[3] = mk(3, 32'd4, 32'd4, 32'd4, 32'd0, 32'd0,
                     32'd4, 32'd4, 3, 3, 1'b0);
        vecs[4] = mk(5, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5,
                     32'd1, 32'd5, 5, 3, 1'b1);
        vecs[5] = mk(2, 32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 32'd0, 32'd0,
                     32'h8000_0000, 32'h7FFF_FFFF, 2, 2, 1'b0);
        vecs[6] = mk(4, 32'hFFFF_FFFB, 32'hFFFF_FFFE, 32'hFFFF_FFF7, 32'hFFFF_FFF7, 32'd0,
                     32'hFFFF_FFF7, 32'hFFFF_FFFE, 4, 3, 1'b1);

        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
        #2 rst = 1'b0;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_min", out_min, 32'd0);
        check("rst_out_count", {16'd0, out_count}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        step();

        // Directed table.
        foreach (vecs[v]) begin
            frame_q.delete();
            for (int i = 0; i < int'(vecs[v].len); i++) frame_q.push_back(vecs[v].s[i]);
            send_frame();
            check_result(vecs[v].emin, vecs[v].emax, vecs[v].ecnt, 1'b0,
                         vecs[v].scnt, vecs[v].ssat, v % 2);
        end

        // Backpressure: held sample 9 must wait until the result is consumed.
        out_ready = 1'b0;
        frame_q = '{32'd1, 32'd2};
        send_frame();
        check("bp_valid", {31'd0, out_valid}, 32'd1);
        held_min = 32'd1;
        held_max = 32'd2;
        in_valid = 1'b1; in_data = 32'd9; in_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_min", out_min, held_min);
            check("bp_max", out_max, held_max);
            check("bp_count", {16'd0, out_count}, 32'd2);
        end
        out_ready = 1'b1;
        step();
        check("bp_xfer_valid", {31'd0, out_valid}, 32'd0);
        check("bp_xfer_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0; in_last = 1'b0;
        check_result(32'd9, 32'd9, 16'd1, 1'b0, 2'd1, 1'b0, 0);

        // Reset while a result is pending takes effect without a clock edge.
        out_ready = 1'b0;
        frame_q = '{32'd77, 32'hFFFF_FF00};
        send_frame();
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("async_in_ready", {31'd0, in_ready}, 32'd1);
        check("async_out_valid", {31'd0, out_valid}, 32'd0);
        check("async_out_min", out_min, 32'd0);
        check("async_out_max", out_max, 32'd0);
        check("async_out_count", {16'd0, out_count}, 32'd0);
        check("async_out_sat", {31'd0, s_out_sat}, 32'd0);
        step();
        rst = 1'b1;
        out_ready = 1'b1;
        step();

        // Mid-frame reset discards the partial frame.
        in_valid = 1'b1; in_last = 1'b0; in_data = 32'd3;
        step();
        in_data = 32'hFFFF_FFF9;
        step();
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1 rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("midrst_no_valid", {31'd0, out_valid}, 32'd0);
        end
        frame_q = '{32'd10};
        send_frame();
        check_result(32'd10, 32'd10, 16'd1, 1'b0, 2'd1, 1'b0, 0);

        // Random frames against the reference model.
        for (int f = 0; f < 40; f++) begin
            int len;
            len = $urandom_range(1, 6);
            frame_q.delete();
            for (int i = 0; i < len; i++) begin
                case ($urandom_range(0, 5))
                    0:       frame_q.push_back(32'h8000_0000);
                    1:       frame_q.push_back(32'h7FFF_FFFF);
                    2:       frame_q.push_back(32'($urandom_range(0, 7)) - 32'd4);
                    default: frame_q.push_back($urandom);
                endcase
            end
            send_frame();
            model_check($urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
